eth_rx_mac_filter: RTL and testbench



---
 rtl/eth_pkg.sv | 16 +
 rtl/eth_rx_addr_match.sv | 25 ++
 rtl/eth_rx_mac_filter.sv | 192 +++++++++++++++++++
 tb/tb_eth_rx_mac_filter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet RX definitions: header geometry, broadcast address and the
// frame-filter state encoding.
package eth_pkg;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned ETH_MAC_W   = 48;
    localparam logic [ETH_MAC_W-1:0] ETH_BCAST_MAC = '1;

    typedef enum logic [1:0] {
        HDR,
        REPLAY,
        PASS,
        DROP
    } eth_rx_state_e;

endpackage

// File: rtl/eth_rx_addr_match.sv
// Combinational destination-MAC accept function shared by the RX filter and
// any future loopback filter.
module eth_rx_addr_match
    import eth_pkg::*;
(
    input  logic [ETH_MAC_W-1:0] dest,
    input  logic [ETH_MAC_W-1:0] cfg_local_mac,
    input  logic                 cfg_bcast_en,
    input  logic                 cfg_mcast_en,
    input  logic                 cfg_promisc,
    output logic                 accept
);

    logic is_bcast;

    always_comb begin
        is_bcast = (dest == ETH_BCAST_MAC);
        // dest[40] is the I/G bit of the first byte on the wire.
        accept = (dest == cfg_local_mac)
               | (is_bcast & (cfg_bcast_en | cfg_promisc))
               | (dest[40] & ~is_bcast & (cfg_mcast_en | cfg_promisc))
               | cfg_promisc;
    end

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Receive destination-address filter: buffers the 14-byte header, decides
// accept/drop, replays accepted headers and passes the payload through.
module eth_rx_mac_filter
    import eth_pkg::*;
#(
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    input  logic [47:0]           cfg_local_mac,
    input  logic                  cfg_bcast_en,
    input  logic                  cfg_mcast_en,
    input  logic                  cfg_promisc,
    output logic [STAT_WIDTH-1:0] stat_accept,
    output logic [STAT_WIDTH-1:0] stat_drop_filter,
    output logic [STAT_WIDTH-1:0] stat_drop_runt,
    output logic                  evt_accept,
    output logic                  evt_drop_filter,
    output logic                  evt_drop_runt
);

    localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_LEN - 1);

    eth_rx_state_e   state_q, state_d;
    logic [7:0]      hdr_q [ETH_HDR_LEN];
    logic [7:0]      hdr_d [ETH_HDR_LEN];
    logic [3:0]      cnt_q, cnt_d, idx_q, idx_d;
    logic            last14_q, last14_d, tuser_q, tuser_d;
    logic [47:0]     dest_q, dest_d, src_q, src_d;
    logic [15:0]     type_q, type_d;
    logic [STAT_WIDTH-1:0] acc_q, acc_d, flt_q, flt_d, runt_q, runt_d;
    logic            evt_acc_q, evt_acc_d, evt_flt_q, evt_flt_d, evt_runt_q, evt_runt_d;

    logic        s_hs, m_hs, hdr_beat, decide, runt, accept;
    logic [47:0] dest_w;

    assign dest_w = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};

    eth_rx_addr_match u_match (
        .dest          (dest_w),
        .cfg_local_mac (cfg_local_mac),
        .cfg_bcast_en  (cfg_bcast_en),
        .cfg_mcast_en  (cfg_mcast_en),
        .cfg_promisc   (cfg_promisc),
        .accept        (accept)
    );

    always_comb begin
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        unique case (state_q)
            REPLAY: begin
                s_axis_tready = 1'b0;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_q[idx_q];
                if (idx_q == HDR_LAST && last14_q) begin
                    m_axis_tlast = 1'b1;
                    m_axis_tuser = tuser_q;
                end
            end
            PASS: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
            end
            default: ;
        endcase
    end

    assign s_hs     = s_axis_tvalid & s_axis_tready;
    assign m_hs     = m_axis_tvalid & m_axis_tready;
    assign hdr_beat = (state_q == HDR) & s_hs;
    assign decide   = hdr_beat & (cnt_q == HDR_LAST);
    assign runt     = hdr_beat & s_axis_tlast & (cnt_q != HDR_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HDR:    if (decide) state_d = accept ? REPLAY : (s_axis_tlast ? HDR : DROP);
            REPLAY: if (m_hs && idx_q == HDR_LAST) state_d = last14_q ? HDR : PASS;
            PASS:   if (m_hs && s_axis_tlast) state_d = HDR;
            DROP:   if (s_hs && s_axis_tlast) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        hdr_d      = hdr_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        last14_d   = last14_q;
        tuser_d    = tuser_q;
        dest_d     = dest_q;
        src_d      = src_q;
        type_d     = type_q;
        acc_d      = acc_q;
        flt_d      = flt_q;
        runt_d     = runt_q;
        evt_acc_d  = 1'b0;
        evt_flt_d  = 1'b0;
        evt_runt_d = 1'b0;
        if (hdr_beat) begin
            hdr_d[cnt_q] = s_axis_tdata;
            cnt_d = (s_axis_tlast || cnt_q == HDR_LAST) ? '0 : cnt_q + 4'd1;
        end
        // Byte 13 is still on the bus at the decision edge, so take it directly.
        if (decide) begin
            last14_d = s_axis_tlast;
            tuser_d  = s_axis_tuser;
            dest_d   = dest_w;
            src_d    = {hdr_q[6], hdr_q[7], hdr_q[8], hdr_q[9], hdr_q[10], hdr_q[11]};
            type_d   = {hdr_q[12], s_axis_tdata};
            if (accept) begin
                acc_d     = acc_q + STAT_WIDTH'(1);
                evt_acc_d = 1'b1;
            end else begin
                flt_d     = flt_q + STAT_WIDTH'(1);
                evt_flt_d = 1'b1;
            end
        end
        if (runt) begin
            runt_d     = runt_q + STAT_WIDTH'(1);
            evt_runt_d = 1'b1;
        end
        if (state_q == REPLAY && m_hs) idx_d = (idx_q == HDR_LAST) ? '0 : idx_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HDR;
            for (int unsigned i = 0; i < ETH_HDR_LEN; i++) hdr_q[i] <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            last14_q   <= 1'b0;
            tuser_q    <= 1'b0;
            dest_q     <= '0;
            src_q      <= '0;
            type_q     <= '0;
            acc_q      <= '0;
            flt_q      <= '0;
            runt_q     <= '0;
            evt_acc_q  <= 1'b0;
            evt_flt_q  <= 1'b0;
            evt_runt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            last14_q   <= last14_d;
            tuser_q    <= tuser_d;
            dest_q     <= dest_d;
            src_q      <= src_d;
            type_q     <= type_d;
            acc_q      <= acc_d;
            flt_q      <= flt_d;
            runt_q     <= runt_d;
            evt_acc_q  <= evt_acc_d;
            evt_flt_q  <= evt_flt_d;
            evt_runt_q <= evt_runt_d;
        end
    end

    assign m_eth_dest_mac   = dest_q;
    assign m_eth_src_mac    = src_q;
    assign m_eth_type       = type_q;
    assign stat_accept      = acc_q;
    assign stat_drop_filter = flt_q;
    assign stat_drop_runt   = runt_q;
    assign evt_accept       = evt_acc_q;
    assign evt_drop_filter  = evt_flt_q;
    assign evt_drop_runt    = evt_runt_q;

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Self-checking bench for eth_rx_mac_filter: directed frame table, reset
// corner, and a randomised frame mix against a byte scoreboard.
module tb_eth_rx_mac_filter;

    localparam int unsigned SW = 32;
    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC   = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_FB;
    localparam int K_RUNT = 0, K_ACC = 1, K_FLT = 2;

    logic clk = 1'b0;
    logic rst;
    logic [7:0]  s_axis_tdata, m_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [47:0] m_eth_dest_mac, m_eth_src_mac, cfg_local_mac;
    logic [15:0] m_eth_type;
    logic        cfg_bcast_en, cfg_mcast_en, cfg_promisc;
    logic [SW-1:0] stat_accept, stat_drop_filter, stat_drop_runt;
    logic        evt_accept, evt_drop_filter, evt_drop_runt;

    eth_rx_mac_filter #(.STAT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
        .cfg_local_mac(cfg_local_mac), .cfg_bcast_en(cfg_bcast_en), .cfg_mcast_en(cfg_mcast_en),
        .cfg_promisc(cfg_promisc),
        .stat_accept(stat_accept), .stat_drop_filter(stat_drop_filter), .stat_drop_runt(stat_drop_runt),
        .evt_accept(evt_accept), .evt_drop_filter(evt_drop_filter), .evt_drop_runt(evt_drop_runt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; logic last; logic user; } beat_t;
    typedef struct { logic [47:0] dest; bit be; bit me; bit pe; int len; bit user; int kind; } vec_t;

    beat_t exp_q[$];
    beat_t mb;
    logic [7:0] frm[$];
    vec_t vecs[13];
    int errors = 0, checks = 0;
    int exp_acc = 0, exp_flt = 0, exp_runt = 0;
    int evt_acc_n = 0, evt_flt_n = 0, evt_runt_n = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (evt_accept)      evt_acc_n++;
            if (evt_drop_filter) evt_flt_n++;
            if (evt_drop_runt)   evt_runt_n++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h last %0b expected no output", m_axis_tdata, m_axis_tlast);
                end else begin
                    mb = exp_q.pop_front();
                    check("out_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, {mb.data, mb.last, mb.user});
                end
            end
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic bit model_accept(input logic [47:0] d, input bit b, input bit m, input bit p);
        if (p) return 1'b1;
        if (d == LOCAL) return 1'b1;
        if (d == BCAST) return b;
        if (d[40]) return m;
        return 1'b0;
    endfunction

    task automatic build_frame(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] et, input int len);
        logic [7:0] seed;
        seed = 8'($urandom);
        frm.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6)        frm.push_back(dest[47 - 8*i -: 8]);
            else if (i < 12)  frm.push_back(src[47 - 8*(i-6) -: 8]);
            else if (i == 12) frm.push_back(et[15:8]);
            else if (i == 13) frm.push_back(et[7:0]);
            else              frm.push_back(seed + 8'(i));
        end
    endtask

    task automatic expect_frame(input int kind, input bit user);
        beat_t b;
        case (kind)
            K_ACC: begin
                exp_acc++;
                for (int i = 0; i < frm.size(); i++) begin
                    b.data = frm[i];
                    b.last = (i == frm.size() - 1);
                    b.user = b.last ? user : 1'b0;
                    exp_q.push_back(b);
                end
            end
            K_FLT:   exp_flt++;
            default: exp_runt++;
        endcase
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic l, input logic u, input int gap_pct, output bit ok);
        int n;
        n = 0;
        while (gap_pct > 0 && n < 3 && $urandom_range(0, 99) < gap_pct) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u; s_axis_tvalid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no s_axis_tready in 200 cycles expected handshake");
        end
    endtask

    task automatic send_frame(input bit user, input int gap_pct, input int nbytes, output int cycles);
        bit ok;
        bit last;
        int t0;
        t0 = cyc;
        for (int i = 0; i < nbytes; i++) begin
            last = (i == frm.size() - 1);
            drive_beat(frm[i], last, last ? user : 1'b0, gap_pct, ok);
            if (!ok) break;
        end
        cycles = cyc - t0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stat_accept"}, stat_accept, exp_acc);
        check({tag, "_stat_drop_filter"}, stat_drop_filter, exp_flt);
        check({tag, "_stat_drop_runt"}, stat_drop_runt, exp_runt);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_tdata_last_user"}, {m_axis_tdata, m_axis_tlast, m_axis_tuser}, 0);
        check({tag, "_s_tready"}, s_axis_tready, 1);
        check({tag, "_m_eth"}, {m_eth_dest_mac, m_eth_type}, 0);
        check({tag, "_m_eth_src"}, m_eth_src_mac, 0);
        check({tag, "_stats"}, {stat_accept, stat_drop_filter}, 0);
        check({tag, "_stat_runt"}, stat_drop_runt, 0);
        check({tag, "_evts"}, {evt_accept, evt_drop_filter, evt_drop_runt}, 0);
    endtask

    initial begin
        int cycles;
        vec_t v;
        logic [47:0] dest;
        int kind, len, sel;
        bit user;

        vecs[0]  = '{LOCAL, 0, 0, 0, 64, 0, K_ACC};
        vecs[1]  = '{BCAST, 0, 0, 0, 60, 0, K_FLT};
        vecs[2]  = '{LOCAL, 0, 0, 0, 64, 0, K_ACC};
        vecs[3]  = '{MCAST, 0, 1, 0, 20, 0, K_ACC};
        vecs[4]  = '{MCAST, 0, 0, 1, 20, 1, K_ACC};
        vecs[5]  = '{MCAST, 0, 0, 0, 20, 0, K_FLT};
        vecs[6]  = '{LOCAL, 0, 0, 0,  1, 0, K_RUNT};
        vecs[7]  = '{LOCAL, 0, 0, 0, 13, 0, K_RUNT};
        vecs[8]  = '{LOCAL, 0, 0, 0, 14, 1, K_ACC};
        vecs[9]  = '{BCAST, 1, 0, 0, 14, 0, K_ACC};
        vecs[10] = '{48'h02_00_00_00_00_02, 0, 0, 1, 30, 0, K_ACC};
        vecs[11] = '{48'h02_00_00_00_00_02, 0, 0, 0, 14, 0, K_FLT};
        vecs[12] = '{BCAST, 0, 1, 0, 25, 0, K_FLT};

        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        cfg_local_mac = LOCAL; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0; cfg_promisc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            v = vecs[i];
            cfg_bcast_en = v.be; cfg_mcast_en = v.me; cfg_promisc = v.pe;
            build_frame(v.dest, SRC, 16'h0800, v.len);
            expect_frame(v.kind, v.user);
            send_frame(v.user, 0, v.len, cycles);
            // 64 input beats plus 14 stall cycles while the header is replayed
            if (i == 2) check("b2b_input_cycles", cycles, 78);
            drain();
            check_stats($sformatf("vec%0d", i));
            if (v.len >= 14) begin
                check($sformatf("vec%0d_dest", i), m_eth_dest_mac, v.dest);
                check($sformatf("vec%0d_src", i), m_eth_src_mac, SRC);
                check($sformatf("vec%0d_type", i), m_eth_type, 16'h0800);
            end
        end

        // Reset in the middle of an accepted frame's pass-through section.
        cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0; cfg_promisc = 1'b0;
        build_frame(LOCAL, SRC, 16'h86DD, 40);
        for (int i = 0; i < 20; i++) exp_q.push_back('{frm[i], 1'b0, 1'b0});
        send_frame(1'b0, 0, 20, cycles);
        drain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_vals("midpass_reset");
        exp_acc = 0; exp_flt = 0; exp_runt = 0;
        evt_acc_n = 0; evt_flt_n = 0; evt_runt_n = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        build_frame(LOCAL, SRC, 16'h0800, 32);
        expect_frame(K_ACC, 1'b1);
        send_frame(1'b1, 0, 32, cycles);
        drain();
        check_stats("post_reset");

        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0:       dest = LOCAL;
                1:       dest = BCAST;
                2:       dest = {8'h01, 8'h00, 8'h5E, 24'($urandom)};
                3:       dest = {7'($urandom), 1'b0, 40'({$urandom, $urandom})};
                default: dest = {$urandom, 16'($urandom)};
            endcase
            cfg_bcast_en = 1'($urandom); cfg_mcast_en = 1'($urandom); cfg_promisc = ($urandom_range(0, 3) == 0);
            len  = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(1, 24);
            user = 1'($urandom);
            kind = (len < 14) ? K_RUNT : (model_accept(dest, cfg_bcast_en, cfg_mcast_en, cfg_promisc) ? K_ACC : K_FLT);
            build_frame(dest, {$urandom, 16'($urandom)}, 16'($urandom), len);
            expect_frame(kind, user);
            send_frame(user, 20, len, cycles);
        end
        drain();
        repeat (2) @(posedge clk);
        #1;
        check_stats("random");
        check("evt_accept_pulses", evt_acc_n, exp_acc);
        check("evt_drop_filter_pulses", evt_flt_n, exp_flt);
        check("evt_drop_runt_pulses", evt_runt_n, exp_runt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
